// File: rtl/mult_seq_pkg.sv
// ============================================================
// mult_seq_pkg: shared constants and FSM state type for the operand sequencer.
// Rev 1.0
// ============================================================
`default_nettype none

package mult_seq_pkg;

    localparam int DEF_W      = 8;
    localparam int DEF_SETTLE = 2;
    localparam int CNT_W      = 4;

    typedef enum logic [1:0] {
        S_A    = 2'd0,
        S_B    = 2'd1,
        S_MUL  = 2'd2,
        S_DONE = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/key_edge_sync.sv
// ============================================================
// key_edge_sync: 3-flop synchronizer with a one-cycle rising-edge pulse per key press.
// Rev 1.0
// ============================================================
`default_nettype none

module key_edge_sync (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic key_i,
    output logic press_o
);

    logic [2:0] sync_q;
    logic [2:0] sync_d;
    logic [1:0] warm_q;
    logic       arm_q;

    assign sync_d = {sync_q[1:0], key_i};

    // The cleared flops look like a released key, so a key held through reset
    // would fake an edge; arm only once a real low level has reached sync_q[1].
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync_q <= '0;
            warm_q <= '0;
            arm_q  <= 1'b0;
        end else begin
            sync_q <= sync_d;
            warm_q <= {warm_q[0], 1'b1};
            if (warm_q[1] && !sync_q[1]) begin
                arm_q <= 1'b1;
            end
        end
    end

    assign press_o = sync_q[1] & ~sync_q[2] & arm_q;

endmodule

`default_nettype wire

// File: rtl/mult_operand_sequencer.sv
// ============================================================
// mult_operand_sequencer: loads A then B from one switch field, waits SETTLE cycles, registers A*B.
// Rev 1.0
// ============================================================
`default_nettype none

module mult_operand_sequencer
    import mult_seq_pkg::*;
#(
    parameter int W      = DEF_W,
    parameter int SETTLE = DEF_SETTLE
) (
    input  logic             Clock,
    input  logic             Resetn,
    input  logic             Load,
    input  logic [W-1:0]     Data,
    input  logic [2*W-1:0]   P,
    output logic [W-1:0]     A,
    output logic [W-1:0]     B,
    output logic [2*W-1:0]   Result,
    output logic             Valid,
    output logic             Busy,
    output logic [1:0]       State
);

    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(SETTLE - 1);

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [W-1:0]       a_q;
    logic [W-1:0]       b_q;
    logic [2*W-1:0]     result_q;
    logic               valid_q;
    logic               press;

    key_edge_sync u_load_sync (
        .clk_i   (Clock),
        .rst_ni  (Resetn),
        .key_i   (Load),
        .press_o (press)
    );

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            state_q  <= S_A;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            case (state_q)
                S_A, S_DONE: begin
                    if (press) begin
                        a_q     <= Data;
                        valid_q <= 1'b0;
                        state_q <= S_B;
                    end
                end
                S_B: begin
                    if (press) begin
                        b_q     <= Data;
                        cnt_q   <= CNT_INIT;
                        state_q <= S_MUL;
                    end
                end
                S_MUL: begin
                    // Presses here are dropped so the operands stay steady while P settles.
                    if (cnt_q == '0) begin
                        result_q <= P;
                        valid_q  <= 1'b1;
                        state_q  <= S_DONE;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
            endcase
        end
    end

    assign A      = a_q;
    assign B      = b_q;
    assign Result = result_q;
    assign Valid  = valid_q;
    assign Busy   = (state_q == S_MUL);
    assign State  = state_q;

endmodule

`default_nettype wire

// File: tb/tb_mult_operand_sequencer.sv
// ============================================================
// tb_mult_operand_sequencer: scoreboard bench with a press-level reference model.
// Rev 1.0
// ============================================================
`default_nettype none

module tb_mult_operand_sequencer;
    import mult_seq_pkg::*;

    localparam int W = 8;

    logic clk = 1'b0;
    always #10 clk = ~clk;

    logic           rstn;
    logic           ld0, ld1;
    logic [W-1:0]   d0, d1;
    logic [2*W-1:0] p0, p1;
    logic [W-1:0]   a0, b0, a1, b1;
    logic [2*W-1:0] r0, r1;
    logic           v0, v1, bz0, bz1;
    logic [1:0]     s0, s1;

    // Behavioural stand-in for the external array multiplier.
    assign p0 = {{W{1'b0}}, a0} * {{W{1'b0}}, b0};
    assign p1 = {{W{1'b0}}, a1} * {{W{1'b0}}, b1};

    mult_operand_sequencer #(.W(W), .SETTLE(2)) dut0 (
        .Clock(clk), .Resetn(rstn), .Load(ld0), .Data(d0), .P(p0),
        .A(a0), .B(b0), .Result(r0), .Valid(v0), .Busy(bz0), .State(s0)
    );

    mult_operand_sequencer #(.W(W), .SETTLE(1)) dut1 (
        .Clock(clk), .Resetn(rstn), .Load(ld1), .Data(d1), .P(p1),
        .A(a1), .B(b1), .Result(r1), .Valid(v1), .Busy(bz1), .State(s1)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual %0h required %0h", nm, act, exp);
    endtask

    typedef struct {
        logic [2*W-1:0] prod;
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        int             at;
    } exp_t;

    exp_t         q0[$];
    exp_t         q1[$];
    logic [W-1:0] m_a [2];
    logic [W-1:0] m_b [2];
    bit           m_next_b [2];
    int           busy_until [2];

    function automatic int settle_of(int i);
        return (i == 0) ? 2 : 1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_a[i]        = '0;
            m_b[i]        = '0;
            m_next_b[i]   = 1'b0;
            busy_until[i] = -1;
        end
        q0.delete();
        q1.delete();
    endtask

    // A press taking effect at edge e: dropped while a product is settling,
    // otherwise it alternately supplies operand A then operand B.
    task automatic model_press(int i, int e, logic [W-1:0] d);
        exp_t x;
        if (e <= busy_until[i]) return;
        if (!m_next_b[i]) begin
            m_a[i]      = d;
            m_next_b[i] = 1'b1;
        end else begin
            m_b[i]        = d;
            m_next_b[i]   = 1'b0;
            busy_until[i] = e + settle_of(i);
            x.prod = (2*W)'(m_a[i]) * (2*W)'(m_b[i]);
            x.a    = m_a[i];
            x.b    = m_b[i];
            x.at   = busy_until[i];
            if (i == 0) q0.push_back(x);
            else        q1.push_back(x);
        end
    endtask

    task automatic set_in(int i, logic l, logic [W-1:0] d);
        if (i == 0) begin ld0 = l; d0 = d; end
        else        begin ld1 = l; d1 = d; end
    endtask

    task automatic set_ld(int i, logic l);
        if (i == 0) ld0 = l;
        else        ld1 = l;
    endtask

    // Load rises before edge cyc+1; the press acts at edge cyc+3.
    task automatic press(int i, logic [W-1:0] d, int hold, int idle);
        @(negedge clk);
        set_in(i, 1'b1, d);
        model_press(i, cyc + 3, d);
        repeat (hold) @(negedge clk);
        set_ld(i, 1'b0);
        repeat (idle) @(negedge clk);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        model_reset();
        repeat (4) @(negedge clk);
    endtask

    task automatic check_pop(int i, logic [2*W-1:0] r, logic [W-1:0] a, logic [W-1:0] b);
        exp_t x;
        if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
            n_chk++;
            $display("FAIL sb_unexpected_valid%0d: actual valid=1 result %0h required no pending product", i, r);
        end else begin
            x = (i == 0) ? q0.pop_front() : q1.pop_front();
            chk($sformatf("sb_result%0d", i), 32'(r), 32'(x.prod));
            chk($sformatf("sb_latency%0d", i), cyc, x.at);
            chk($sformatf("sb_operands%0d", i), {16'h0, a, b}, {16'h0, x.a, x.b});
        end
    endtask

    logic pv0 = 1'b0;
    logic pv1 = 1'b0;
    always @(negedge clk) begin
        if (v0 && !pv0) check_pop(0, r0, a0, b0);
        if (v1 && !pv1) check_pop(1, r1, a1, b1);
        pv0 <= v0;
        pv1 <= v1;
    end

    initial begin
        repeat (20000) @(posedge clk);
        $display("FAIL watchdog: actual no finish required finish within budget");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rstn = 1'b0;
        ld0 = 1'b0; ld1 = 1'b0;
        d0 = '0;    d1 = '0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_A", 32'(a0), 0);
        chk("rst_B", 32'(b0), 0);
        chk("rst_Result", 32'(r0), 0);
        chk("rst_Valid", 32'(v0), 0);
        chk("rst_Busy", 32'(bz0), 0);
        chk("rst_State", 32'(s0), 32'(S_A));
        rstn = 1'b1;
        repeat (4) @(negedge clk);

        // 0x0F * 0x0F
        press(0, 8'h0F, 1, 3);
        chk("t1_state_b", 32'(s0), 32'(S_B));
        chk("t1_A", 32'(a0), 32'h0F);
        press(0, 8'h0F, 1, 3);
        chk("t1_busy", 32'(bz0), 1);
        chk("t1_state_mul", 32'(s0), 32'(S_MUL));
        repeat (3) @(negedge clk);
        chk("t1_valid", 32'(v0), 1);
        chk("t1_result", 32'(r0), 32'h00E1);
        chk("t1_state_done", 32'(s0), 32'(S_DONE));

        // 0xFF * 0xFF, then a new A in S_DONE keeps the old Result
        press(0, 8'hFF, 1, 3);
        press(0, 8'hFF, 1, 6);
        chk("t2_result", 32'(r0), 32'hFE01);
        press(0, 8'h00, 1, 3);
        chk("t2_valid_low", 32'(v0), 0);
        chk("t2_A_zero", 32'(a0), 0);
        chk("t2_result_hold", 32'(r0), 32'hFE01);
        press(0, 8'h55, 1, 6);
        chk("t2_result_zero", 32'(r0), 0);
        chk("t2_valid", 32'(v0), 1);

        // Load held for 20 cycles in S_A gives one press
        pulse_reset();
        press(0, 8'h21, 20, 3);
        chk("t3_state_b", 32'(s0), 32'(S_B));
        chk("t3_A", 32'(a0), 32'h21);
        chk("t3_B_untouched", 32'(b0), 0);
        press(0, 8'h03, 1, 6);
        chk("t3_B", 32'(b0), 32'h03);
        chk("t3_result", 32'(r0), 32'h0063);

        // Press during S_MUL is discarded
        press(0, 8'h07, 1, 3);
        @(negedge clk);
        d0 = 8'h09; ld0 = 1'b1;
        model_press(0, cyc + 3, 8'h09);
        @(negedge clk);
        ld0 = 1'b0;
        @(negedge clk);
        ld0 = 1'b1;
        model_press(0, cyc + 3, 8'h33);
        @(negedge clk);
        d0 = 8'h33;
        @(negedge clk);
        ld0 = 1'b0;
        repeat (5) @(negedge clk);
        chk("t4_state_done", 32'(s0), 32'(S_DONE));
        chk("t4_B_kept", 32'(b0), 32'h09);
        chk("t4_result", 32'(r0), 32'h003F);

        // Reset during S_MUL with Load high
        press(0, 8'h11, 1, 3);
        press(0, 8'h22, 1, 0);
        @(negedge clk);
        ld0 = 1'b1;
        @(negedge clk);
        chk("t5_in_mul", 32'(s0), 32'(S_MUL));
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        model_reset();
        chk("t5_A", 32'(a0), 0);
        chk("t5_B", 32'(b0), 0);
        chk("t5_Result", 32'(r0), 0);
        chk("t5_Valid", 32'(v0), 0);
        chk("t5_Busy", 32'(bz0), 0);
        chk("t5_State", 32'(s0), 32'(S_A));
        repeat (10) @(negedge clk);
        chk("t5_no_capture_state", 32'(s0), 32'(S_A));
        chk("t5_no_capture_A", 32'(a0), 0);
        ld0 = 1'b0;
        repeat (4) @(negedge clk);
        press(0, 8'h05, 1, 3);
        press(0, 8'h06, 1, 6);
        chk("t5_after_result", 32'(r0), 32'h001E);

        // SETTLE=1 instance
        press(1, 8'h80, 1, 3);
        press(1, 8'h02, 1, 3);
        chk("t6_result", 32'(r1), 32'h0100);
        chk("t6_valid", 32'(v1), 1);
        chk("t6_state", 32'(s1), 32'(S_DONE));

        // Random operand pairs on both instances
        for (int n = 0; n < 8; n++) begin
            press(n % 2, 8'($urandom_range(0, 255)), 1 + n % 3, 3);
            press(n % 2, 8'($urandom_range(0, 255)), 1, 6);
        end

        repeat (5) @(negedge clk);
        chk("sb_drain0", q0.size(), 0);
        chk("sb_drain1", q1.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
